// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0001_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [0:0] {
    StReq,
    StResp
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_p4;
    logic        predicted;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry output + skid buffer between instruction memory and IF/ID.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         consume_i,
  input  logic         flush_i,
  output logic         head_valid_o,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t out_q, out_d;
  fetch_entry_t skid_q, skid_d;
  logic         out_valid_q, out_valid_d;
  logic         skid_valid_q, skid_valid_d;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (consume_i && out_valid_q) begin
      out_d        = skid_q;
      out_valid_d  = skid_valid_q;
      skid_valid_d = 1'b0;
    end

    // A push lands in the first free slot after this cycle's consume.
    if (push_i) begin
      if (!out_valid_d) begin
        out_d       = push_entry_i;
        out_valid_d = 1'b1;
      end else if (!skid_valid_d) begin
        skid_d       = push_entry_i;
        skid_valid_d = 1'b1;
      end
    end

    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign head_valid_o = out_valid_q;
  assign head_o       = out_q;
  assign full_o       = skid_valid_q;
  assign empty_o      = ~out_valid_q;

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns the fetch PC, arbitrates redirects, runs the single-outstanding
// imem handshake and feeds IF/ID through an output + skid buffer.
module fetch_seq_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_redir_valid,
  input  logic [31:0] csr_redir_pc,
  input  logic        miss_redir_valid,
  input  logic [31:0] miss_redir_pc,
  input  logic        early_redir_valid,
  input  logic [31:0] early_redir_pc,
  output logic [31:0] lookup_pc,
  input  logic        btb_hit,
  input  logic        btb_taken,
  input  logic [31:0] btb_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_p4,
  output logic        if_predicted,
  output logic        flush_id
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         pred_q, pred_d;
  logic         kill_q, kill_d;

  logic         redir_valid;
  logic [31:0]  redir_pc;
  logic         gnt_fire;
  logic         push;
  fetch_entry_t push_entry;
  logic         buf_head_valid;
  fetch_entry_t buf_head;
  logic         buf_full;
  logic         buf_empty;

  always_comb begin
    redir_valid = csr_redir_valid | miss_redir_valid | early_redir_valid;
    if (csr_redir_valid) begin
      redir_pc = csr_redir_pc;
    end else if (miss_redir_valid) begin
      redir_pc = miss_redir_pc;
    end else begin
      redir_pc = early_redir_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      pred_q     <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      pred_q     <= pred_d;
      kill_q     <= kill_d;
    end
  end

  assign gnt_fire = imem_req & imem_gnt;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    pred_d     = pred_q;
    kill_d     = kill_q;
    push       = 1'b0;

    unique case (state_q)
      StReq: begin
        if (gnt_fire) begin
          state_d    = StResp;
          fetch_pc_d = pc_q;
          pred_d     = btb_hit & btb_taken;
          // The granted fetch is already wrong-path if a redirect lands with it.
          kill_d     = redir_valid;
          pc_d       = (btb_hit & btb_taken) ? btb_target : pc_q + 32'd4;
        end
      end
      StResp: begin
        if (imem_rvalid) begin
          state_d = StReq;
          kill_d  = 1'b0;
          push    = ~kill_q & ~redir_valid;
        end else if (redir_valid) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = StReq;
    endcase

    if (redir_valid) begin
      pc_d = redir_pc;
    end
  end

  always_comb begin
    imem_req  = rst & (state_q == StReq) & ~buf_full;
    imem_addr = pc_q;
    lookup_pc = pc_q;
    flush_id  = rst & (csr_redir_valid | miss_redir_valid);
  end

  always_comb begin
    push_entry.inst      = imem_rdata;
    push_entry.pc        = fetch_pc_q;
    push_entry.pc_p4     = fetch_pc_q + 32'd4;
    push_entry.predicted = pred_q;
  end

  fetch_skid_buf u_skid_buf (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .consume_i    (~buf_empty & ~stall),
    .flush_i      (redir_valid),
    .head_valid_o (buf_head_valid),
    .head_o       (buf_head),
    .full_o       (buf_full),
    .empty_o      (buf_empty)
  );

  assign if_valid     = buf_head_valid;
  assign if_inst      = buf_head_valid ? buf_head.inst : NOP_INST;
  assign if_pc        = buf_head.pc;
  assign if_pc_p4     = buf_head.pc_p4;
  assign if_predicted = buf_head_valid & buf_head.predicted;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl: transaction-level model plus directed and random stimulus.
module tb_fetch_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'h0001_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_redir_valid, miss_redir_valid, early_redir_valid;
  logic [31:0] csr_redir_pc, miss_redir_pc, early_redir_pc, lookup_pc;
  logic        btb_hit, btb_taken;
  logic [31:0] btb_target;
  logic        stall, imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, if_predicted, flush_id;
  logic [31:0] if_inst, if_pc, if_pc_p4;

  fetch_seq_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .csr_redir_valid   (csr_redir_valid),
    .csr_redir_pc      (csr_redir_pc),
    .miss_redir_valid  (miss_redir_valid),
    .miss_redir_pc     (miss_redir_pc),
    .early_redir_valid (early_redir_valid),
    .early_redir_pc    (early_redir_pc),
    .lookup_pc         (lookup_pc),
    .btb_hit           (btb_hit),
    .btb_taken         (btb_taken),
    .btb_target        (btb_target),
    .stall             (stall),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_gnt          (imem_gnt),
    .imem_rvalid       (imem_rvalid),
    .imem_rdata        (imem_rdata),
    .if_valid          (if_valid),
    .if_inst           (if_inst),
    .if_pc             (if_pc),
    .if_pc_p4          (if_pc_p4),
    .if_predicted      (if_predicted),
    .flush_id          (flush_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // Model: fetch PC, one outstanding fetch, and an in-order queue of deliverable words.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc, m_fpc;
  logic        m_busy, m_kill, m_pred;

  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;

  logic        d_gnt, d_stall, d_csr, d_miss, d_early, d_hit, d_taken;
  logic [31:0] d_csr_pc, d_miss_pc, d_early_pc, d_tgt;
  int          d_delay;
  bit          rand_delay;

  logic        s_req, s_valid, s_pred, s_flush;
  logic [31:0] s_addr, s_pc, s_p4, s_inst;

  task automatic model_reset();
    m_pc     = RST_PC;
    m_fpc    = RST_PC;
    m_busy   = 1'b0;
    m_kill   = 1'b0;
    m_pred   = 1'b0;
    mem_pend = 1'b0;
    mem_cnt  = 0;
    mq.delete();
  endtask

  task automatic compare_model();
    bit ev;
    ev = mq.size() > 0;
    chk("imem_req", imem_req, !m_busy && mq.size() < 2);
    chk("imem_addr", imem_addr, m_pc);
    chk("lookup_pc", lookup_pc, m_pc);
    chk("if_valid", if_valid, ev);
    chk("flush_id", flush_id, d_csr | d_miss);
    if (ev) begin
      chk("if_inst", if_inst, mq[0].inst);
      chk("if_pc", if_pc, mq[0].pc);
      chk("if_pc_p4", if_pc_p4, mq[0].pc + 32'd4);
      chk("if_predicted", if_predicted, mq[0].pred);
    end else begin
      chk("if_inst_nop", if_inst, NOP);
    end
  endtask

  task automatic step_model();
    bit          redir, push;
    logic [31:0] rpc;
    redir = d_csr | d_miss | d_early;
    rpc   = d_csr ? d_csr_pc : (d_miss ? d_miss_pc : d_early_pc);
    push  = 0;
    if (!m_busy) begin
      if (mq.size() < 2 && d_gnt) begin
        m_busy = 1'b1;
        m_fpc  = m_pc;
        m_pred = d_hit & d_taken;
        m_kill = redir;
        m_pc   = m_pred ? d_tgt : m_pc + 32'd4;
      end
    end else if (imem_rvalid) begin
      m_busy = 1'b0;
      push   = !m_kill && !redir;
      m_kill = 1'b0;
    end else if (redir) begin
      m_kill = 1'b1;
    end
    if (redir) m_pc = rpc;
    if (mq.size() > 0 && !d_stall) void'(mq.pop_front());
    if (push) mq.push_back('{memf(m_fpc), m_fpc, m_pred});
    if (redir) mq.delete();
  endtask

  task automatic drive_idle();
    d_gnt = 1'b1; d_stall = 1'b0; d_csr = 1'b0; d_miss = 1'b0; d_early = 1'b0;
    d_hit = 1'b0; d_taken = 1'b0; d_tgt = '0;
    d_csr_pc = '0; d_miss_pc = '0; d_early_pc = '0;
    d_delay = 1; rand_delay = 0;
    imem_gnt = 1'b0; stall = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    csr_redir_valid = 1'b0; miss_redir_valid = 1'b0; early_redir_valid = 1'b0;
    csr_redir_pc = '0; miss_redir_pc = '0; early_redir_pc = '0;
    btb_hit = 1'b0; btb_taken = 1'b0; btb_target = '0;
  endtask

  // One clock: drive after the edge, compare at the falling edge, advance model at the edge.
  task automatic cycle();
    #1;
    imem_gnt          = d_gnt;
    stall             = d_stall;
    csr_redir_valid   = d_csr;
    csr_redir_pc      = d_csr_pc;
    miss_redir_valid  = d_miss;
    miss_redir_pc     = d_miss_pc;
    early_redir_valid = d_early;
    early_redir_pc    = d_early_pc;
    btb_hit           = d_hit;
    btb_taken         = d_taken;
    btb_target        = d_tgt;
    if (mem_pend) begin
      mem_cnt--;
      imem_rvalid = (mem_cnt == 0);
    end else begin
      imem_rvalid = 1'b0;
    end
    imem_rdata = imem_rvalid ? memf(mem_addr) : $urandom;
    @(negedge clk);
    s_req   = imem_req;   s_addr = imem_addr; s_valid = if_valid; s_pc = if_pc;
    s_p4    = if_pc_p4;   s_pred = if_predicted; s_flush = flush_id; s_inst = if_inst;
    compare_model();
    @(posedge clk);
    step_model();
    if (imem_rvalid) mem_pend = 1'b0;
    if (s_req && imem_gnt) begin
      mem_pend = 1'b1;
      mem_addr = s_addr;
      mem_cnt  = rand_delay ? int'($urandom_range(1, 3)) : d_delay;
    end
    d_csr = 1'b0; d_miss = 1'b0; d_early = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_len;
    drive_idle();
    model_reset();
    #1 rst = 1'b0;
    csr_redir_valid = 1'b1;
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_flush", flush_id, 1'b0);
    chk("rst_inst", if_inst, NOP);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_pred", if_predicted, 1'b0);

    // Sequential fetch with a 1-cycle memory.
    do_reset();
    cycle(); chk("seq_addr0", s_addr, 32'h0001_0000); chk("seq_req0", s_req, 1'b1);
    cycle(); chk("seq_valid1", s_valid, 1'b0);
    cycle(); chk("seq_addr1", s_addr, 32'h0001_0004); chk("seq_valid2", s_valid, 1'b1);
    chk("seq_pc2", s_pc, 32'h0001_0000); chk("seq_p4_2", s_p4, 32'h0001_0004);
    chk("seq_inst2", s_inst, memf(32'h0001_0000));
    cycle(); chk("seq_valid3", s_valid, 1'b0);
    cycle(); chk("seq_addr2", s_addr, 32'h0001_0008); chk("seq_pc4", s_pc, 32'h0001_0004);

    // BTB taken at 0x10004.
    do_reset();
    cycle(); cycle();
    d_hit = 1'b1; d_taken = 1'b1; d_tgt = 32'h0001_0040;
    cycle(); chk("btb_addr", s_addr, 32'h0001_0004); chk("btb_pred0", s_pred, 1'b0);
    d_hit = 1'b0; d_taken = 1'b0;
    cycle(); cycle();
    chk("btb_tgt", s_addr, 32'h0001_0040); chk("btb_pc", s_pc, 32'h0001_0004);
    chk("btb_pred1", s_pred, 1'b1);

    // Branch miss while a slow response is outstanding.
    do_reset();
    d_delay = 4;
    cycle();
    d_miss = 1'b1; d_miss_pc = 32'h0001_0100;
    cycle(); chk("miss_flush", s_flush, 1'b1);
    cycle(); chk("miss_flush_off", s_flush, 1'b0); chk("miss_valid3", s_valid, 1'b0);
    cycle();
    d_delay = 1;
    cycle(); chk("miss_drop", s_valid, 1'b0);
    cycle(); chk("miss_req", s_req, 1'b1); chk("miss_addr", s_addr, 32'h0001_0100);
    chk("miss_valid6", s_valid, 1'b0);
    cycle(); chk("miss_valid7", s_valid, 1'b0);
    cycle(); chk("miss_valid8", s_valid, 1'b1); chk("miss_pc8", s_pc, 32'h0001_0100);

    // CSR beats branch miss.
    do_reset();
    d_gnt = 1'b0;
    d_csr = 1'b1; d_csr_pc = 32'h0000_0200; d_miss = 1'b1; d_miss_pc = 32'h0000_0300;
    cycle(); chk("prio_flush", s_flush, 1'b1);
    cycle(); chk("prio_addr", s_addr, 32'h0000_0200); chk("prio_flush_off", s_flush, 1'b0);
    d_gnt = 1'b1;
    cycle(); cycle();

    // Stall fills output and skid, then drains in order.
    do_reset();
    cycle(); cycle();
    d_stall = 1'b1;
    cycle(); chk("stl_pc3", s_pc, 32'h0001_0000); chk("stl_addr3", s_addr, 32'h0001_0004);
    cycle();
    cycle(); chk("stl_req5", s_req, 1'b0);
    cycle();
    cycle(); chk("stl_req7", s_req, 1'b0); chk("stl_pc7", s_pc, 32'h0001_0000);
    d_stall = 1'b0;
    cycle(); chk("stl_pc8", s_pc, 32'h0001_0000); chk("stl_valid8", s_valid, 1'b1);
    chk("stl_req8", s_req, 1'b0);
    cycle(); chk("stl_pc9", s_pc, 32'h0001_0004); chk("stl_req9", s_req, 1'b1);
    chk("stl_addr9", s_addr, 32'h0001_0008);

    // Asynchronous reset while a response is pending.
    do_reset();
    cycle(); cycle();
    d_delay = 3; d_stall = 1'b1;
    cycle(); cycle();
    #3 rst = 1'b0;
    csr_redir_valid = 1'b1;
    #1;
    chk("arst_req", imem_req, 1'b0); chk("arst_valid", if_valid, 1'b0);
    chk("arst_inst", if_inst, NOP); chk("arst_addr", imem_addr, RST_PC);
    chk("arst_flush", flush_id, 1'b0); chk("arst_pred", if_predicted, 1'b0);
    do_reset();
    cycle(); chk("arst_req1", s_req, 1'b1); chk("arst_addr1", s_addr, 32'h0001_0000);

    // Random traffic.
    rand_delay = 1;
    stall_len  = 0;
    for (int i = 0; i < 3000; i++) begin
      d_gnt = ($urandom_range(0, 9) < 6);
      if (stall_len == 0 && $urandom_range(0, 19) == 0) stall_len = $urandom_range(1, 8);
      if (stall_len > 0) begin
        d_stall = 1'b1;
        stall_len--;
      end else begin
        d_stall = ($urandom_range(0, 3) == 0);
      end
      d_csr      = ($urandom_range(0, 39) == 0);
      d_miss     = ($urandom_range(0, 29) == 0);
      d_early    = ($urandom_range(0, 24) == 0);
      d_csr_pc   = $urandom & 32'hFFFF_FFFC;
      d_miss_pc  = $urandom & 32'hFFFF_FFFC;
      d_early_pc = $urandom & 32'hFFFF_FFFC;
      d_hit      = ($urandom_range(0, 2) == 0);
      d_taken    = $urandom_range(0, 1);
      d_tgt      = $urandom & 32'hFFFF_FFFC;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
- Sequences the instruction fetch path and owns the fetch PC register.
- Arbitrates next-PC sources in fixed priority: CSR/trap, branch-miss, early ID-stage branch, BTB prediction, sequential.
- Drives the instruction-memory request/grant/response handshake with one request in flight, and kills wrong-path responses.
- Presents fetched instructions to IF/ID through a 2-entry (output + skid) buffer that honours the downstream stall.

Parameters:
- RESET_PC, 32'h0001_0000, fetch PC loaded at reset.
- NOP_INST, 32'h0000_0013, instruction word driven on if_inst when if_valid=0.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- csr_redir_valid  in  1  trap/mret redirect pulse (highest priority)
- csr_redir_pc  in  32  its target
- miss_redir_valid  in  1  EX branch-miss redirect pulse
- miss_redir_pc  in  32  its target
- early_redir_valid  in  1  ID early-branch redirect pulse
- early_redir_pc  in  32  its target
- lookup_pc  out  32  BTB lookup address (= current fetch PC)
- btb_hit  in  1  BTB hit for lookup_pc (combinational)
- btb_taken  in  1  predictor says taken
- btb_target  in  32  predicted target
- stall  in  1  IF/ID hold; buffer head is consumed when if_valid & !stall
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  instruction word
- if_valid  out  1  buffer head valid
- if_inst  out  32  instruction (NOP_INST when invalid)
- if_pc  out  32  PC of if_inst
- if_pc_p4  out  32  if_pc+4 (fall-through PC for miss recovery)
- if_predicted  out  1  next PC after this instruction came from the BTB
- flush_id  out  1  kill the ID-stage instruction

Behaviour:
- Reset (async, rst=0): pc=RESET_PC; state=REQ; kill=0; output and skid entries invalid; if_predicted=0. While rst=0: imem_req=0, flush_id=0, if_inst=NOP_INST.
- pc, imem_addr, lookup_pc carry the same value.
- Redirect selection each cycle: csr > miss > early. The winner loads pc and clears both buffer entries (if_valid=0 next cycle). The ID instruction is not cleared by this.
- flush_id = csr_redir_valid | miss_redir_valid, combinational. An early redirect does not flush ID.
- FSM states: REQ, RESP.
- REQ:
  - imem_req=1 only when the skid entry is empty; otherwise imem_req=0.
  - The address may change before gnt; the memory permits this.
  - A redirect without gnt: pc takes the target and the request continues from the new PC next cycle.
  - On gnt, latch fetch_pc=pc and pred = btb_hit & btb_taken, then go to RESP.
  - If gnt and a redirect occur in the same cycle, go to RESP with kill=1.
  - On gnt with no redirect, pc <= pred ? btb_target : pc+4 (32-bit wrap).
- RESP:
  - imem_req=0.
  - A redirect sets kill=1, unless imem_rvalid is also high this cycle; then the data is dropped directly.
  - On rvalid with kill=1: discard the data, kill <= 0, go to REQ.
  - On rvalid with kill=0: push {rdata, fetch_pc, fetch_pc+4, pred}. It goes to the output entry if the output is empty or consumed this cycle; otherwise it goes to skid. Then go to REQ.
- Buffer: on consume with skid valid, skid moves to output in the same edge. The skid is never overwritten. The issue rule (single in flight, request only when skid empty) guarantees a free slot.
- Throughput: with gnt in the request cycle and rvalid the next cycle, one instruction every 2 cycles. Back-to-back issue is out of scope.
- Latency: gnt at cycle n, rvalid at cycle m gives if_valid=1 at m+1.
- Redirect in the same cycle as a consume or push: the redirect wins and the buffer ends empty.
- Stall with an empty buffer has no effect.

Decomposition:
- Package fetch_pkg: RESET_PC default, NOP_INST, the state enum {REQ, RESP}, and a struct fetch_entry_t {inst, pc, pc_p4, predicted}.
- Sub-module fetch_skid_buf: 2-entry output+skid buffer with push, consume and flush ports, plus full/empty status.

Test Plan:
- Reset, 1-cycle memory, no stall → addresses 0x10000, 0x10004, 0x10008 issued. if_pc follows with if_valid every 2nd cycle and if_pc_p4 = if_pc+4.
- BTB hit+taken at 0x10004 with target 0x10040 → next imem_addr=0x10040 and the 0x10004 entry has if_predicted=1.
- miss_redir 0x10100 while in RESP, rvalid 3 cycles later → that response is dropped, flush_id pulses 1 cycle, next request is 0x10100, no stale if_valid.
- csr_redir 0x200 and miss_redir 0x300 in the same cycle → pc=0x200, flush_id=1.
- stall held 5 cycles during fetch → output and skid both fill, imem_req stays 0, no data is lost, and in-order delivery resumes on release.
- rst dropped mid-RESP → all outputs return to reset values asynchronously and the first request after release is 0x10000.
